ar_rr_arbiter: RTL and testbench

- Read-address (AR) channel arbiter for one crossbar slave port.
- Collects AR requests from NUM_MASTERS master ports and grants one at a time, using round-robin order.
- Registers the winning request toward the slave, prefixing ARID with the master index so the R path can route data back.
- Limits in-flight reads to MAX_OUTSTANDING, which matches the depth of the downstream pending-request FIFO.

---
 rtl/ar_rr_arbiter.sv | 180 ++++++++++++++++++
 tb/tb_ar_rr_arbiter.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ar_rr_arbiter.sv
// Read-address channel arbiter for one crossbar slave port: round-robin grant (or fixed
// priority when AR_ARB_FIXED_PRIO_EN is defined), registered AR slice, in-flight read limit.
module ar_rr_arbiter #(
  parameter  int NUM_MASTERS     = 4,
  parameter  int ID_WIDTH        = 4,
  parameter  int ADDR_WIDTH      = 32,
  parameter  int LEN_WIDTH       = 4,
  parameter  int SIZE_WIDTH      = 3,
  parameter  int MAX_OUTSTANDING = 4,
  localparam int MW              = $clog2(NUM_MASTERS),
  localparam int OW              = $clog2(MAX_OUTSTANDING + 1)
) (
  input  logic                              ACLK,
  input  logic                              ARESETn,
  input  logic [NUM_MASTERS-1:0]            ARVALID_M,
  output logic [NUM_MASTERS-1:0]            ARREADY_M,
  input  logic [NUM_MASTERS*ID_WIDTH-1:0]   ARID_M,
  input  logic [NUM_MASTERS*ADDR_WIDTH-1:0] ARADDR_M,
  input  logic [NUM_MASTERS*LEN_WIDTH-1:0]  ARLEN_M,
  input  logic [NUM_MASTERS*SIZE_WIDTH-1:0] ARSIZE_M,
  input  logic [NUM_MASTERS*2-1:0]          ARBURST_M,
  output logic                              ARVALID_S,
  input  logic                              ARREADY_S,
  output logic [ID_WIDTH+MW-1:0]            ARID_S,
  output logic [ADDR_WIDTH-1:0]             ARADDR_S,
  output logic [LEN_WIDTH-1:0]              ARLEN_S,
  output logic [SIZE_WIDTH-1:0]             ARSIZE_S,
  output logic [1:0]                        ARBURST_S,
  input  logic                              RVALID_S,
  input  logic                              RREADY_S,
  input  logic                              RLAST_S,
  output logic [OW-1:0]                     outstanding
);

  typedef enum logic {IDLE = 1'b0, HOLD = 1'b1} state_t;

  state_t                 state_q;
  logic                   arvalid_q;
  logic [ID_WIDTH+MW-1:0] arid_q;
  logic [ADDR_WIDTH-1:0]  araddr_q;
  logic [LEN_WIDTH-1:0]   arlen_q;
  logic [SIZE_WIDTH-1:0]  arsize_q;
  logic [1:0]             arburst_q;
  logic [OW-1:0]          outstanding_q, outstanding_d;

  logic [MW-1:0]          rr_base;
  logic [MW-1:0]          win_idx;
  logic                   win_found;
  logic                   grant_ok;
  logic                   ar_hs;
  logic                   r_done;

  logic [ID_WIDTH-1:0]    sel_id;
  logic [ADDR_WIDTH-1:0]  sel_addr;
  logic [LEN_WIDTH-1:0]   sel_len;
  logic [SIZE_WIDTH-1:0]  sel_size;
  logic [1:0]             sel_burst;

`ifdef AR_ARB_FIXED_PRIO_EN
  assign rr_base = '0;
`else
  logic [MW-1:0] rr_ptr_q;
  logic [MW-1:0] grant_q;
  assign rr_base = rr_ptr_q;
`endif

  // Walk from the highest offset down so the closest requester above rr_base wins last.
  always_comb begin : p_winner
    int idx;
    idx       = 0;
    win_found = 1'b0;
    win_idx   = '0;
    for (int i = NUM_MASTERS - 1; i >= 0; i--) begin
      idx = int'(rr_base) + i;
      if (idx >= NUM_MASTERS) idx = idx - NUM_MASTERS;
      if (ARVALID_M[MW'(idx)]) begin
        win_found = 1'b1;
        win_idx   = MW'(idx);
      end
    end
  end

  always_comb begin : p_payload_mux
    sel_id    = '0;
    sel_addr  = '0;
    sel_len   = '0;
    sel_size  = '0;
    sel_burst = '0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      if (MW'(i) == win_idx) begin
        sel_id    = ARID_M[i*ID_WIDTH +: ID_WIDTH];
        sel_addr  = ARADDR_M[i*ADDR_WIDTH +: ADDR_WIDTH];
        sel_len   = ARLEN_M[i*LEN_WIDTH +: LEN_WIDTH];
        sel_size  = ARSIZE_M[i*SIZE_WIDTH +: SIZE_WIDTH];
        sel_burst = ARBURST_M[i*2 +: 2];
      end
    end
  end

  // Reset gating keeps every master stalled while the port is held in reset.
  assign grant_ok = ARESETn && (state_q == IDLE) && win_found &&
                    (outstanding_q < OW'(MAX_OUTSTANDING));

  always_comb begin : p_arready
    ARREADY_M = '0;
    if (grant_ok) ARREADY_M[win_idx] = 1'b1;
  end

  assign ar_hs  = arvalid_q & ARREADY_S;
  assign r_done = RVALID_S & RREADY_S & RLAST_S;

  // A completion at zero is spurious and dropped; a matched issue/complete pair cancels.
  always_comb begin : p_outstanding
    logic dec_ok;
    dec_ok        = r_done && (outstanding_q != '0);
    outstanding_d = outstanding_q;
    if (ar_hs && !dec_ok) begin
      if (outstanding_q != OW'(MAX_OUTSTANDING)) outstanding_d = outstanding_q + 1'b1;
    end else if (!ar_hs && dec_ok) begin
      outstanding_d = outstanding_q - 1'b1;
    end
  end

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) outstanding_q <= '0;
    else          outstanding_q <= outstanding_d;
  end

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      state_q   <= IDLE;
      arvalid_q <= 1'b0;
      arid_q    <= '0;
      araddr_q  <= '0;
      arlen_q   <= '0;
      arsize_q  <= '0;
      arburst_q <= '0;
`ifndef AR_ARB_FIXED_PRIO_EN
      rr_ptr_q  <= '0;
      grant_q   <= '0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (grant_ok) begin
            arvalid_q <= 1'b1;
            arid_q    <= {win_idx, sel_id};
            araddr_q  <= sel_addr;
            arlen_q   <= sel_len;
            arsize_q  <= sel_size;
            arburst_q <= sel_burst;
`ifndef AR_ARB_FIXED_PRIO_EN
            grant_q   <= win_idx;
`endif
            state_q   <= HOLD;
          end
        end
        HOLD: begin
          if (ARREADY_S) begin
            arvalid_q <= 1'b0;
`ifndef AR_ARB_FIXED_PRIO_EN
            rr_ptr_q  <= (grant_q == MW'(NUM_MASTERS - 1)) ? '0 : grant_q + 1'b1;
`endif
            state_q   <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign ARVALID_S   = arvalid_q;
  assign ARID_S      = arid_q;
  assign ARADDR_S    = araddr_q;
  assign ARLEN_S     = arlen_q;
  assign ARSIZE_S    = arsize_q;
  assign ARBURST_S   = arburst_q;
  assign outstanding = outstanding_q;

endmodule

// File: tb/tb_ar_rr_arbiter.sv
// Self-checking bench for ar_rr_arbiter (default round-robin build) with a cycle-level
// reference model of the arbitration rules.
module tb_ar_rr_arbiter;
  localparam int N = 4, IDW = 4, AW = 32, LW = 4, SW = 3, MAXO = 4, MW = 2, OW = 3;

  logic              ACLK = 1'b0;
  logic              ARESETn;
  logic [N-1:0]      ARVALID_M;
  logic [N-1:0]      ARREADY_M;
  logic [N*IDW-1:0]  ARID_M;
  logic [N*AW-1:0]   ARADDR_M;
  logic [N*LW-1:0]   ARLEN_M;
  logic [N*SW-1:0]   ARSIZE_M;
  logic [N*2-1:0]    ARBURST_M;
  logic              ARVALID_S, ARREADY_S;
  logic [IDW+MW-1:0] ARID_S;
  logic [AW-1:0]     ARADDR_S;
  logic [LW-1:0]     ARLEN_S;
  logic [SW-1:0]     ARSIZE_S;
  logic [1:0]        ARBURST_S;
  logic              RVALID_S, RREADY_S, RLAST_S;
  logic [OW-1:0]     outstanding;

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic          m_hold;
  logic [MW-1:0] m_grant;
  int            m_ptr, m_out;
  logic [IDW-1:0] m_id;
  logic [AW-1:0]  m_addr;
  logic [LW-1:0]  m_len;
  logic [SW-1:0]  m_size;
  logic [1:0]     m_burst;

  ar_rr_arbiter dut (
    .ACLK(ACLK), .ARESETn(ARESETn),
    .ARVALID_M(ARVALID_M), .ARREADY_M(ARREADY_M), .ARID_M(ARID_M), .ARADDR_M(ARADDR_M),
    .ARLEN_M(ARLEN_M), .ARSIZE_M(ARSIZE_M), .ARBURST_M(ARBURST_M),
    .ARVALID_S(ARVALID_S), .ARREADY_S(ARREADY_S), .ARID_S(ARID_S), .ARADDR_S(ARADDR_S),
    .ARLEN_S(ARLEN_S), .ARSIZE_S(ARSIZE_S), .ARBURST_S(ARBURST_S),
    .RVALID_S(RVALID_S), .RREADY_S(RREADY_S), .RLAST_S(RLAST_S), .outstanding(outstanding)
  );

  always #5 ACLK = ~ACLK;

  function automatic logic [N-1:0] exp_arready();
    logic [N-1:0] one;
    one = 1;
    if (ARESETn && !m_hold && m_out < MAXO)
      for (int k = 0; k < N; k++) begin
        int j;
        j = (m_ptr + k) % N;
        if (ARVALID_M[j]) return one << j;
      end
    return '0;
  endfunction

  task automatic model_reset();
    m_hold = 0; m_grant = '0; m_ptr = 0; m_out = 0;
    m_id = '0; m_addr = '0; m_len = '0; m_size = '0; m_burst = '0;
  endtask

  // Advance the model on the current inputs, then cross one rising edge.
  task automatic tick();
    logic [N-1:0] r;
    bit inc, dec;
    r   = exp_arready();
    inc = m_hold && ARREADY_S;
    dec = RVALID_S && RREADY_S && RLAST_S && (m_out > 0);
    if (r != 0) begin
      for (int g = 0; g < N; g++)
        if (r[g]) begin
          m_grant = MW'(g);
          m_id    = ARID_M[g*IDW +: IDW];
          m_addr  = ARADDR_M[g*AW +: AW];
          m_len   = ARLEN_M[g*LW +: LW];
          m_size  = ARSIZE_M[g*SW +: SW];
          m_burst = ARBURST_M[g*2 +: 2];
        end
      m_hold = 1;
    end else if (inc) begin
      m_hold = 0;
      m_ptr  = (int'(m_grant) + 1) % N;
    end
    m_out = m_out + int'(inc) - int'(dec);
    if (m_out > MAXO) m_out = MAXO;
    @(posedge ACLK);
    #1;
  endtask

  task automatic rand_payload();
    ARID_M    = N*IDW'($urandom);
    ARLEN_M   = N*LW'($urandom);
    ARSIZE_M  = N*SW'($urandom);
    ARBURST_M = N*2'($urandom);
    for (int i = 0; i < N; i++) ARADDR_M[i*AW +: AW] = $urandom;
  endtask

  task automatic apply_reset();
    ARESETn = 0; ARVALID_M = '0; ARREADY_S = 0;
    RVALID_S = 0; RREADY_S = 0; RLAST_S = 0;
    rand_payload();
    model_reset();
    repeat (2) @(posedge ACLK);
    @(negedge ACLK) ARESETn = 1;
    @(posedge ACLK);
    #1;
  endtask

  task automatic test_reset();
    ARESETn = 0; ARVALID_M = '1; ARREADY_S = 1;
    model_reset();
    repeat (2) @(posedge ACLK);
    #2;
    checks++; if (ARVALID_S !== 1'b0) begin errors++; $display("FAIL reset_arvalid: got %b want 0", ARVALID_S); end
    checks++; if (ARREADY_M !== '0) begin errors++; $display("FAIL reset_arready: got %b want 0000", ARREADY_M); end
    checks++; if (outstanding !== '0) begin errors++; $display("FAIL reset_outstanding: got %0d want 0", outstanding); end
    checks++; if (ARID_S !== '0 || ARADDR_S !== '0 || ARLEN_S !== '0 || ARSIZE_S !== '0 || ARBURST_S !== '0) begin
      errors++; $display("FAIL reset_payload: got id=%h addr=%h want 0", ARID_S, ARADDR_S); end
  endtask

  task automatic test_single();
    apply_reset();
    ARVALID_M = 4'b0100;
    ARID_M[2*IDW +: IDW] = 4'h5;
    ARADDR_M[2*AW +: AW] = 32'h1000;
    #1;
    checks++; if (ARREADY_M !== 4'b0100) begin errors++; $display("FAIL single_arready: got %b want 0100", ARREADY_M); end
    tick();
    ARVALID_M = '0; ARREADY_S = 1;
    #1;
    checks++; if (ARVALID_S !== 1'b1) begin errors++; $display("FAIL single_arvalid: got %b want 1", ARVALID_S); end
    checks++; if (ARID_S !== 6'b10_0101) begin errors++; $display("FAIL single_arid: got %b want 100101", ARID_S); end
    checks++; if (ARADDR_S !== 32'h1000) begin errors++; $display("FAIL single_araddr: got %h want 00001000", ARADDR_S); end
    tick();
    ARREADY_S = 0;
    #1;
    checks++; if (outstanding !== 3'd1) begin errors++; $display("FAIL single_outstanding: got %0d want 1", outstanding); end
    checks++; if (ARVALID_S !== 1'b0) begin errors++; $display("FAIL single_arvalid_drop: got %b want 0", ARVALID_S); end
  endtask

  task automatic test_round_robin();
    int order[$];
    int cyc[$];
    apply_reset();
    ARVALID_M = '1; ARREADY_S = 1; RVALID_S = 1; RREADY_S = 1; RLAST_S = 1;
    for (int c = 0; c < 10; c++) begin
      #1;
      checks++; if (ARREADY_M !== exp_arready()) begin errors++; $display("FAIL rr_arready_c%0d: got %b want %b", c, ARREADY_M, exp_arready()); end
      for (int i = 0; i < N; i++) if (ARREADY_M[i]) begin order.push_back(i); cyc.push_back(c); end
      tick();
    end
    RVALID_S = 0; RREADY_S = 0; RLAST_S = 0;
    checks++; if (order.size() != 5) begin errors++; $display("FAIL rr_grant_count: got %0d want 5", order.size()); end
    for (int k = 0; k < order.size() && k < 5; k++) begin
      checks++; if (order[k] != k % 4) begin errors++; $display("FAIL rr_order_%0d: got %0d want %0d", k, order[k], k % 4); end
      checks++; if (cyc[k] != 2 * k) begin errors++; $display("FAIL rr_spacing_%0d: got cycle %0d want %0d", k, cyc[k], 2 * k); end
    end
  endtask

  task automatic test_backpressure();
    logic [IDW+MW-1:0] eid;
    logic [AW-1:0] eaddr;
    apply_reset();
    ARVALID_M = 4'b0010;
    eid   = {2'd1, ARID_M[1*IDW +: IDW]};
    eaddr = ARADDR_M[1*AW +: AW];
    #1;
    checks++; if (ARREADY_M !== 4'b0010) begin errors++; $display("FAIL bp_arready_grant: got %b want 0010", ARREADY_M); end
    tick();
    ARVALID_M = '1;
    for (int c = 0; c < 5; c++) begin
      rand_payload();
      #1;
      checks++; if (ARVALID_S !== 1'b1) begin errors++; $display("FAIL bp_arvalid_c%0d: got %b want 1", c, ARVALID_S); end
      checks++; if (ARID_S !== eid || ARADDR_S !== eaddr) begin errors++; $display("FAIL bp_payload_c%0d: got %h/%h want %h/%h", c, ARID_S, ARADDR_S, eid, eaddr); end
      checks++; if (ARREADY_M !== '0) begin errors++; $display("FAIL bp_arready_c%0d: got %b want 0000", c, ARREADY_M); end
      tick();
    end
    ARREADY_S = 1;
    #1;
    checks++; if (ARVALID_S !== 1'b1) begin errors++; $display("FAIL bp_arvalid_hs: got %b want 1", ARVALID_S); end
    tick();
    ARREADY_S = 0; ARVALID_M = '0;
    #1;
    checks++; if (outstanding !== 3'd1 || ARVALID_S !== 1'b0) begin errors++; $display("FAIL bp_after_hs: got out=%0d vld=%b want 1/0", outstanding, ARVALID_S); end
  endtask

  task automatic test_outstanding_limit();
    apply_reset();
    ARVALID_M = 4'b0001; ARREADY_S = 1;
    repeat (8) tick();
    #1;
    checks++; if (outstanding !== 3'd4) begin errors++; $display("FAIL lim_full: got %0d want 4", outstanding); end
    for (int c = 0; c < 3; c++) begin
      checks++; if (ARREADY_M !== '0 || ARVALID_S !== 1'b0) begin errors++; $display("FAIL lim_stall_c%0d: got rdy=%b vld=%b want 0000/0", c, ARREADY_M, ARVALID_S); end
      tick();
      #1;
    end
    RVALID_S = 1; RREADY_S = 1; RLAST_S = 1;
    #1;
    checks++; if (ARREADY_M !== '0) begin errors++; $display("FAIL lim_rlast_cycle: got %b want 0000", ARREADY_M); end
    tick();
    RVALID_S = 0; RREADY_S = 0; RLAST_S = 0;
    #1;
    checks++; if (outstanding !== 3'd3) begin errors++; $display("FAIL lim_freed: got %0d want 3", outstanding); end
    checks++; if (ARREADY_M !== 4'b0001) begin errors++; $display("FAIL lim_regrant: got %b want 0001", ARREADY_M); end
    tick();
    ARVALID_M = '0;
    #1;
    checks++; if (ARVALID_S !== 1'b1 || ARID_S[IDW+MW-1:IDW] !== 2'd0) begin errors++; $display("FAIL lim_5th_issued: got vld=%b idx=%0d want 1/0", ARVALID_S, ARID_S[IDW+MW-1:IDW]); end
  endtask

  task automatic test_simultaneous();
    apply_reset();
    ARVALID_M = 4'b1000; ARREADY_S = 1;
    repeat (4) tick();
    ARREADY_S = 0;
    tick();
    #1;
    checks++; if (outstanding !== 3'd2 || ARVALID_S !== 1'b1) begin errors++; $display("FAIL sim_setup: got out=%0d vld=%b want 2/1", outstanding, ARVALID_S); end
    ARREADY_S = 1; ARVALID_M = '0; RVALID_S = 1; RREADY_S = 1; RLAST_S = 1;
    tick();
    ARREADY_S = 0; RVALID_S = 0; RREADY_S = 0; RLAST_S = 0;
    #1;
    checks++; if (outstanding !== 3'd2) begin errors++; $display("FAIL sim_unchanged: got %0d want 2", outstanding); end
    checks++; if (ARVALID_S !== 1'b0) begin errors++; $display("FAIL sim_arvalid: got %b want 0", ARVALID_S); end
  endtask

  task automatic test_reset_hold();
    apply_reset();
    ARVALID_M = 4'b0010; ARREADY_S = 1;
    repeat (2) tick();
    ARREADY_S = 0;
    tick();
    #1;
    checks++; if (ARVALID_S !== 1'b1 || outstanding !== 3'd1) begin errors++; $display("FAIL rh_setup: got vld=%b out=%0d want 1/1", ARVALID_S, outstanding); end
    ARESETn = 0;
    model_reset();
    #1;
    checks++; if (ARVALID_S !== 1'b0) begin errors++; $display("FAIL rh_arvalid: got %b want 0", ARVALID_S); end
    checks++; if (outstanding !== '0 || ARID_S !== '0) begin errors++; $display("FAIL rh_state: got out=%0d id=%h want 0/0", outstanding, ARID_S); end
    ARVALID_M = '0;
    @(negedge ACLK) ARESETn = 1;
    @(posedge ACLK);
    #1;
    ARVALID_M = '1;
    #1;
    checks++; if (ARREADY_M !== 4'b0001) begin errors++; $display("FAIL rh_restart_m0: got %b want 0001", ARREADY_M); end
    tick();
    ARVALID_M = '0;
  endtask

  task automatic test_random();
    apply_reset();
    for (int c = 0; c < 400; c++) begin
      ARVALID_M = N'($urandom);
      rand_payload();
      ARREADY_S = ($urandom_range(0, 2) != 0);
      RLAST_S   = 1'($urandom_range(0, 1));
      RVALID_S  = ($urandom_range(0, 3) != 0);
      RREADY_S  = ($urandom_range(0, 3) != 0);
      #1;
      checks++; if (ARREADY_M !== exp_arready()) begin errors++; $display("FAIL rnd_arready_c%0d: got %b want %b", c, ARREADY_M, exp_arready()); end
      checks++; if (ARVALID_S !== m_hold) begin errors++; $display("FAIL rnd_arvalid_c%0d: got %b want %b", c, ARVALID_S, m_hold); end
      checks++; if (outstanding !== OW'(m_out)) begin errors++; $display("FAIL rnd_outstanding_c%0d: got %0d want %0d", c, outstanding, m_out); end
      checks++; if (ARID_S !== {m_grant, m_id} || ARADDR_S !== m_addr || ARLEN_S !== m_len ||
                    ARSIZE_S !== m_size || ARBURST_S !== m_burst) begin
        errors++; $display("FAIL rnd_payload_c%0d: got %h/%h/%h/%h/%h want %h/%h/%h/%h/%h", c,
                           ARID_S, ARADDR_S, ARLEN_S, ARSIZE_S, ARBURST_S,
                           {m_grant, m_id}, m_addr, m_len, m_size, m_burst); end
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_backpressure();
    test_outstanding_limit();
    test_simultaneous();
    test_reset_hold();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
